// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-layer time-step scheduler.
//   sched_state_t : scheduler FSM state encoding
//   neuron_idx_w  : index width helper (never narrower than 1 bit)
//   sat_inc       : saturating increment used by the per-neuron spike counters
package snn_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_FETCH  = 3'd2,
      S_APPLY  = 3'd3,
      S_SAMPLE = 3'd4,
      S_DONE   = 3'd5
   } sched_state_t;

   // Width needed to index n items; a range of one still gets a 1-bit vector.
   function automatic int neuron_idx_w(input int n);
      if (n <= 1) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

   // Increment val but never beyond max_val.
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
      if (val >= max_val) begin
         return max_val;
      end else begin
         return val + 32'd1;
      end
   endfunction

endpackage

// File: rtl/snn_refrac_timer.sv
// Refractory hold timer for one neuron: a loadable down-counter.
//   clk      : clock
//   rst_n    : asynchronous active-low reset (clears the count)
//   load     : load load_val this cycle (takes priority over counting)
//   load_val : value to load
//   active   : count is nonzero, i.e. the neuron is being held in reset
module snn_refrac_timer #(
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          active
);

   logic [TW-1:0] r_count;

   // Load on request, otherwise count down to zero and stay there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= {TW{1'b0}};
      end else if (load) begin
         r_count <= load_val;
      end else if (r_count != {TW{1'b0}}) begin
         r_count <= r_count - TW'(1);
      end else begin
         r_count <= r_count;
      end
   end

   assign active = (r_count != {TW{1'b0}});

endmodule

// File: rtl/snn_step_scheduler.sv
// Time-step scheduler for one layer of integrate-and-fire neurons.
// Takes one input spike vector per step (valid/ready), pulses it onto the
// shared layer bus for one cycle, samples neuron spikes the following cycle,
// counts them per neuron with refractory masking, and reports counts plus
// the argmax winner after NUM_STEPS steps.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : begin a sample (only honoured when idle)
//   in_valid/in_ready/in_spikes : input vector handshake
//   neuron_spike  : spike_out of every neuron
//   layer_spikes  : shared spike bus to every neuron's spike_in
//   neuron_rst    : per-neuron reset (clear and refractory hold)
//   spike_counts  : packed per-neuron counters, neuron i at [i*CNT_WIDTH +: CNT_WIDTH]
//   winner/winner_valid : index of the highest count, any count nonzero
//   busy, done    : not idle, one-cycle end-of-sample pulse
module snn_step_scheduler
   import snn_pkg::*;
#(
   parameter int NUM_INPUTS  = 4,
   parameter int NUM_NEURONS = 4,
   parameter int NUM_STEPS   = 16,
   parameter int REFRAC      = 2,
   parameter int CNT_WIDTH   = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [NUM_INPUTS-1:0]            in_spikes,
   input  logic [NUM_NEURONS-1:0]           neuron_spike,
   output logic [NUM_INPUTS-1:0]            layer_spikes,
   output logic [NUM_NEURONS-1:0]           neuron_rst,
   output logic [NUM_NEURONS*CNT_WIDTH-1:0] spike_counts,
   output logic [$clog2(NUM_NEURONS)-1:0]   winner,
   output logic                             winner_valid,
   output logic                             busy,
   output logic                             done
);

   localparam int          NEURON_IDX_W = neuron_idx_w(NUM_NEURONS);
   localparam int          STEP_W       = neuron_idx_w(NUM_STEPS);
   localparam int          TIMER_W      = neuron_idx_w(REFRAC + 2);
   localparam logic [31:0] CNT_MAX      = (32'd1 << CNT_WIDTH) - 32'd1;

   sched_state_t              r_state;
   logic [STEP_W-1:0]         r_step;
   logic [CNT_WIDTH-1:0]      r_cnt [NUM_NEURONS];
   logic [NEURON_IDX_W-1:0]   r_winner;
   logic                      r_winner_valid;
   logic                      r_in_ready;
   logic [NUM_INPUTS-1:0]     r_layer_spikes;
   logic                      r_busy;
   logic                      r_done;

   logic [NUM_NEURONS-1:0]    w_timer_active;
   logic [NUM_NEURONS-1:0]    w_timer_load;
   logic [NUM_NEURONS-1:0]    w_fire;
   logic [TIMER_W-1:0]        w_timer_val;
   logic [NEURON_IDX_W-1:0]   w_best_idx;
   logic [CNT_WIDTH-1:0]      w_best_cnt;
   logic                      w_any;

   // Timers are zeroed in CLEAR; in SAMPLE a counted fire arms the hold window.
   always_comb begin
      w_timer_load = {NUM_NEURONS{1'b0}};
      w_fire       = {NUM_NEURONS{1'b0}};
      w_timer_val  = TIMER_W'(REFRAC + 1);
      if (r_state == S_CLEAR) begin
         w_timer_load = {NUM_NEURONS{1'b1}};
         w_timer_val  = {TIMER_W{1'b0}};
      end else if (r_state == S_SAMPLE) begin
         // A neuron still in its refractory window cannot fire again.
         w_fire       = neuron_spike & ~w_timer_active;
         w_timer_load = w_fire;
      end else begin
         w_timer_load = {NUM_NEURONS{1'b0}};
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_NEURONS; gi++) begin : g_timer
         snn_refrac_timer #(
            .TW(TIMER_W)
         ) u_timer (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (w_timer_load[gi]),
            .load_val (w_timer_val),
            .active   (w_timer_active[gi])
         );
      end
   endgenerate

   // Neurons are held in reset during our own reset, during CLEAR and while refractory.
   assign neuron_rst = {NUM_NEURONS{~rst_n}}
                     | {NUM_NEURONS{r_state == S_CLEAR}}
                     | w_timer_active;

   // Argmax over the counts; strict compare keeps the lowest index on ties.
   always_comb begin
      w_best_idx = {NEURON_IDX_W{1'b0}};
      w_best_cnt = r_cnt[0];
      w_any      = 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (r_cnt[i] != {CNT_WIDTH{1'b0}}) begin
            w_any = 1'b1;
         end else begin
            w_any = w_any;
         end
      end
      for (int i = 1; i < NUM_NEURONS; i++) begin
         if (r_cnt[i] > w_best_cnt) begin
            w_best_cnt = r_cnt[i];
            w_best_idx = NEURON_IDX_W'(i);
         end else begin
            w_best_cnt = w_best_cnt;
         end
      end
   end

   // Scheduler FSM; every externally visible flag is registered for the next state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_IDLE;
         r_step         <= {STEP_W{1'b0}};
         r_winner       <= {NEURON_IDX_W{1'b0}};
         r_winner_valid <= 1'b0;
         r_in_ready     <= 1'b0;
         r_layer_spikes <= {NUM_INPUTS{1'b0}};
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            r_cnt[i] <= {CNT_WIDTH{1'b0}};
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= S_CLEAR;
                  r_busy  <= 1'b1;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_CLEAR: begin
               r_step         <= {STEP_W{1'b0}};
               r_winner       <= {NEURON_IDX_W{1'b0}};
               r_winner_valid <= 1'b0;
               for (int i = 0; i < NUM_NEURONS; i++) begin
                  r_cnt[i] <= {CNT_WIDTH{1'b0}};
               end
               r_in_ready <= 1'b1;
               r_state    <= S_FETCH;
            end
            S_FETCH: begin
               if (in_valid && r_in_ready) begin
                  r_layer_spikes <= in_spikes;
                  r_in_ready     <= 1'b0;
                  r_state        <= S_APPLY;
               end else begin
                  r_state <= S_FETCH;
               end
            end
            S_APPLY: begin
               r_layer_spikes <= {NUM_INPUTS{1'b0}};
               r_state        <= S_SAMPLE;
            end
            S_SAMPLE: begin
               for (int i = 0; i < NUM_NEURONS; i++) begin
                  if (w_fire[i]) begin
                     r_cnt[i] <= CNT_WIDTH'(sat_inc(32'(r_cnt[i]), CNT_MAX));
                  end else begin
                     r_cnt[i] <= r_cnt[i];
                  end
               end
               if (r_step == STEP_W'(NUM_STEPS - 1)) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_step     <= r_step + STEP_W'(1);
                  r_in_ready <= 1'b1;
                  r_state    <= S_FETCH;
               end
            end
            S_DONE: begin
               r_done         <= 1'b0;
               r_busy         <= 1'b0;
               r_winner       <= w_best_idx;
               r_winner_valid <= w_any;
               r_state        <= S_IDLE;
            end
            default: begin
               r_state        <= S_IDLE;
               r_in_ready     <= 1'b0;
               r_layer_spikes <= {NUM_INPUTS{1'b0}};
               r_busy         <= 1'b0;
               r_done         <= 1'b0;
            end
         endcase
      end
   end

   // Pack the counters onto the flat output bus.
   always_comb begin
      spike_counts = {(NUM_NEURONS*CNT_WIDTH){1'b0}};
      for (int i = 0; i < NUM_NEURONS; i++) begin
         spike_counts[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt[i];
      end
   end

   assign in_ready     = r_in_ready;
   assign layer_spikes = r_layer_spikes;
   assign winner       = r_winner;
   assign winner_valid = r_winner_valid;
   assign busy         = r_busy;
   assign done         = r_done;

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Self-checking bench for snn_step_scheduler. Each sample is planned up front
// from the behavioural rules (per-cycle phase, bus contents, reset windows,
// final counts/winner); a negedge monitor compares the DUT against the plan
// and pops the end-of-sample result queue whenever done is seen.
module tb_snn_step_scheduler;

   localparam int NI   = 4;
   localparam int NN   = 4;
   localparam int NS   = 8;
   localparam int RF   = 2;
   localparam int CW   = 2;
   localparam int CMAX = 3;
   localparam int WW   = 2;

   // phase codes per cycle
   localparam int P_IDLE = 0, P_CLEAR = 1, P_FETCH = 2, P_APPLY = 3, P_SAMPLE = 4, P_DONE = 5;

   logic              clk;
   logic              rst_n;
   logic              start;
   logic              in_valid;
   logic              in_ready;
   logic [NI-1:0]     in_spikes;
   logic [NN-1:0]     neuron_spike;
   logic [NI-1:0]     layer_spikes;
   logic [NN-1:0]     neuron_rst;
   logic [NN*CW-1:0]  spike_counts;
   logic [WW-1:0]     winner;
   logic              winner_valid;
   logic              busy;
   logic              done;

   snn_step_scheduler #(
      .NUM_INPUTS (NI),
      .NUM_NEURONS(NN),
      .NUM_STEPS  (NS),
      .REFRAC     (RF),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_spikes    (in_spikes),
      .neuron_spike (neuron_spike),
      .layer_spikes (layer_spikes),
      .neuron_rst   (neuron_rst),
      .spike_counts (spike_counts),
      .winner       (winner),
      .winner_valid (winner_valid),
      .busy         (busy),
      .done         (done)
   );

   typedef struct {
      logic [NN*CW-1:0] counts;
      int               win;
      bit               val;
      int               done_cyc;
   } res_t;

   res_t          exp_q[$];
   int            ph[int];
   logic [NI-1:0] layer_exp[int];
   logic [NN-1:0] rst_exp[int];
   bit            valid_drv[int];
   logic [NI-1:0] vec_drv[int];
   logic [NN-1:0] nspk_drv[int];
   bit            start_drv[int];

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   int abort_cyc = -1;
   int end_cyc = 0;
   int w_exp = 0;
   bit v_exp = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
      end
   endtask

   // Build the cycle-by-cycle plan and expected result for one sample.
   task automatic plan_sample(input int mode, input int abort_step);
      int c, d, best;
      int lf[NN];
      int cnt[NN];
      logic [NN-1:0] ns, mask;
      logic [NI-1:0] vec;
      res_t r;
      c = cyc + 1;
      start_drv[c] = 1'b1;
      c++;
      ph[c] = P_CLEAR;
      rst_exp[c] = {NN{1'b1}};
      c++;
      for (int i = 0; i < NN; i++) begin
         lf[i] = -1000;
         cnt[i] = 0;
      end
      for (int k = 0; k < NS; k++) begin
         case (mode)
            1:       d = 0;
            2, 4:    d = 1;
            3:       d = (k == 2) ? 5 : 0;
            default: d = int'($urandom_range(0, 2));
         endcase
         for (int j = 0; j < d; j++) begin
            ph[c] = P_FETCH;
            valid_drv[c] = 1'b0;
            c++;
         end
         vec = NI'($urandom);
         ph[c] = P_FETCH;
         valid_drv[c] = 1'b1;
         vec_drv[c] = vec;
         c++;
         ph[c] = P_APPLY;
         layer_exp[c] = vec;
         c++;
         ph[c] = P_SAMPLE;
         case (mode)
            1:       ns = 4'b0001;
            2:       ns = (k < 3) ? 4'b0101 : ((k == 3) ? 4'b1000 : 4'b0000);
            3:       ns = 4'b0000;
            4:       ns = 4'b1000;
            default: ns = NN'($urandom);
         endcase
         nspk_drv[c] = ns;
         if (k == abort_step) begin
            abort_cyc = c;
            return;
         end
         for (int i = 0; i < NN; i++) begin
            // counted only if the previous hold window has fully expired
            if (ns[i] && (c >= lf[i] + RF + 2)) begin
               cnt[i] = (cnt[i] < CMAX) ? cnt[i] + 1 : CMAX;
               lf[i] = c;
               mask = NN'(1) << i;
               for (int t = 1; t <= RF + 1; t++) begin
                  if (rst_exp.exists(c + t)) rst_exp[c + t] = rst_exp[c + t] | mask;
                  else rst_exp[c + t] = mask;
               end
            end
         end
         c++;
      end
      ph[c] = P_DONE;
      end_cyc = c;
      best = 0;
      r.val = 1'b0;
      r.counts = '0;
      for (int i = 0; i < NN; i++) begin
         if (cnt[i] > cnt[best]) best = i;
         if (cnt[i] != 0) r.val = 1'b1;
         r.counts[i*CW +: CW] = CW'(cnt[i]);
      end
      r.win = best;
      r.done_cyc = c;
      exp_q.push_back(r);
   endtask

   // Drive inputs #1 after each rising edge up to and including cycle 'last'.
   task automatic run_cycles(input int last);
      int c, p;
      while (cyc < last) begin
         @(posedge clk);
         #1;
         rst_n = 1'b1;
         c = cyc;
         p = ph.exists(c) ? ph[c] : P_IDLE;
         if (start_drv.exists(c)) start = 1'b1;
         else if (p != P_IDLE) start = 1'($urandom);
         else start = 1'b0;
         in_valid     = (p == P_FETCH) ? valid_drv[c] : 1'($urandom);
         in_spikes    = vec_drv.exists(c) ? vec_drv[c] : NI'($urandom);
         neuron_spike = nspk_drv.exists(c) ? nspk_drv[c] : NN'($urandom);
         if (c == abort_cyc) begin
            #2;
            rst_n = 1'b0;
         end
      end
   endtask

   // Monitor: compare every cycle against the plan, pop results on done.
   always @(negedge clk) begin
      int c, p;
      logic [NN-1:0] er;
      logic [NI-1:0] el;
      res_t r;
      c = cyc;
      p = ph.exists(c) ? ph[c] : P_IDLE;
      if (!rst_n) begin
         check("rst_in_ready", 32'(in_ready), 32'd0);
         check("rst_layer_spikes", 32'(layer_spikes), 32'd0);
         check("rst_busy", 32'(busy), 32'd0);
         check("rst_done", 32'(done), 32'd0);
         check("rst_neuron_rst", 32'(neuron_rst), 32'hF);
         check("rst_counts", 32'(spike_counts), 32'd0);
         check("rst_winner", {30'd0, winner}, 32'd0);
         check("rst_winner_valid", 32'(winner_valid), 32'd0);
         w_exp = 0;
         v_exp = 1'b0;
      end else begin
         er = rst_exp.exists(c) ? rst_exp[c] : '0;
         el = (p == P_APPLY) ? layer_exp[c] : '0;
         check("in_ready", 32'(in_ready), 32'(p == P_FETCH));
         check("layer_spikes", 32'(layer_spikes), 32'(el));
         check("busy", 32'(busy), 32'(p != P_IDLE));
         check("done", 32'(done), 32'(p == P_DONE));
         check("neuron_rst", 32'(neuron_rst), 32'(er));
         check("winner", {30'd0, winner}, 32'(w_exp));
         check("winner_valid", 32'(winner_valid), 32'(v_exp));
         if (done) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 32'd1, 32'd0);
            end else begin
               r = exp_q.pop_front();
               check("spike_counts", 32'(spike_counts), 32'(r.counts));
               check("done_cycle", 32'(c), 32'(r.done_cyc));
               w_exp = r.win;
               v_exp = r.val;
            end
         end else if (p == P_CLEAR) begin
            w_exp = 0;
            v_exp = 1'b0;
         end
      end
   end

   initial begin
      int modes[8] = '{0, 1, 2, 3, 4, 5, 0, 0};
      rst_n = 1'b0;
      start = 1'b0;
      in_valid = 1'b0;
      in_spikes = '0;
      neuron_spike = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_cycles(cyc + 3);
      foreach (modes[m]) begin
         if (modes[m] == 5) begin
            plan_sample(5, 1);
            run_cycles(abort_cyc + 1);
            abort_cyc = -1;
         end else begin
            plan_sample(modes[m], -1);
            run_cycles(end_cyc);
            if (m % 2 == 1) run_cycles(cyc + int'($urandom_range(1, 4)));
         end
      end
      run_cycles(cyc + 6);
      check("results_outstanding", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
